axi_7seg_bcd_writer: RTL and testbench
======================================

Name: axi_7seg_bcd_writer

Overview:
Upstream feeder for the AXI4-Lite 7-segment display controller. Accepts a binary value plus decimal-point mask over a valid/ready port. Converts the value to NDISP BCD digits with a sequential double-dabble, then acts as an AXI4-Lite write master. It writes the digit word to the controller's segment register and, when the mask has changed, to its DP register.

Parameters:
NDISP, 8, number of digits / displays [2..8]; must match the downstream controller
BIN_WIDTH, 27, binary input width; must satisfy 2**BIN_WIDTH > 10**NDISP - 1
ADDR_WIDTH, 3, AXI address width
DATA_WIDTH, 32, AXI data width
ADDR_SEG, 0, downstream segment-digit register address
ADDR_DP, 4, downstream decimal-point register address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_value  in  BIN_WIDTH  unsigned binary value to display
in_dp  in  NDISP  decimal-point mask; bit i = digit i
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
busy  out  1  high whenever FSM not in IDLE
overflow  out  1  one-cycle pulse when accepted value exceeds 10**NDISP-1
err  out  1  sticky flag; set by any non-OKAY bresp
awaddr  out  ADDR_WIDTH  AXI write address
awprot  out  3  constant 3'b000
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata  out  DATA_WIDTH  AXI write data
wstrb  out  DATA_WIDTH/8  constant all ones
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bresp  in  2  AXI write response
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready

Behaviour:
- Reset (sync, rst=1 at clk edge): FSM=IDLE; awvalid=wvalid=bready=0; awaddr=0; wdata=0; overflow=0; err=0; busy=0; in_ready=0. The dp cache is invalidated, so the next request always writes DP.
- in_ready=1 only in IDLE; it goes registered high the cycle after reset releases.
- States: IDLE, CONVERT, WR_SEG, RESP_SEG, WR_DP, RESP_DP.
- IDLE: on in_valid&&in_ready, capture in_value and in_dp.
  - If in_value > 10**NDISP-1: load the BCD register with all 4'hF, pulse overflow for 1 cycle, go to WR_SEG.
  - Otherwise clear the BCD register, load the shift register, go to CONVERT.
- CONVERT: exactly BIN_WIDTH cycles, counted by a down-counter. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shreg} left by 1. Go to WR_SEG after the last shift.
- WR_SEG: awaddr=ADDR_SEG and wdata = BCD word (nibble i = digit i, digit 0 least significant/rightmost). Bits above NDISP*4 are 0.
  - On state entry, assert awvalid and wvalid together in the same cycle.
  - Each valid drops in the cycle after its own handshake; awaddr and wdata stay stable until both handshakes are done.
  - AW-first, W-first and simultaneous handshakes are all legal. Go to RESP_SEG when both are done.
- RESP_SEG: bready=1. On bvalid: if bresp != 2'b00, set err. Then:
  - go to WR_DP if the dp cache is invalid or in_dp differs from the cache;
  - else go to IDLE.
- WR_DP / RESP_DP: same handshake as WR_SEG / RESP_SEG, with awaddr=ADDR_DP and wdata = zero-extended in_dp. On bvalid, update the cache to in_dp and mark it valid (even on error), then go to IDLE.
- Error responses never abort the sequence; err clears only on reset.
- The AXI master never issues a new AW/W before the previous B is received (one outstanding write).
- Latency, in-range request with zero-wait slave: accept → first awvalid = BIN_WIDTH+1 cycles.
- Reset mid-transaction drops all valids at once. The downstream slave is reset by the same reset domain.

Test Plan:
- After reset: in_value=12345678, in_dp=8'h04 → AW addr 0 wdata 32'h12345678, then AW addr 4 wdata 32'h00000004; in_ready returns high after the second B; err=0.
- Next request in_value=42, in_dp=8'h04 (unchanged) → single write, addr 0, wdata 32'h00000042; no DP write.
- in_value=100000000 → overflow high for exactly 1 cycle; write addr 0 wdata 32'hFFFFFFFF; no CONVERT cycles elapse.
- Slave holds awready low 5 cycles with wready=1 → wvalid drops after 1 handshake while awvalid and awaddr/wdata stay stable; exactly one write is observed.
- Slave returns bresp=2'b10 on the segment write → err=1 stays set; the DP write still completes; a later OKAY write leaves err=1.
- rst asserted for 1 cycle mid-CONVERT → next cycle all outputs are at reset values; a following request with the previous in_dp still issues a DP write.

Source files
------------

// File: rtl/axi_7seg_bcd_writer.sv
// ============================================================================
// Module      : axi_7seg_bcd_writer
// Description : Converts a binary value to BCD digits (sequential double-dabble)
//               and writes it plus the decimal-point mask to a 7-seg controller
//               over AXI4-Lite.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_7seg_bcd_writer #(
  parameter int NDISP      = 8,
  parameter int BIN_WIDTH  = 27,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SEG   = 0,
  parameter int ADDR_DP    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_WIDTH-1:0]    in_value,
  input  logic [NDISP-1:0]        in_dp,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int c_bcd_w = NDISP * 4;
  localparam int c_cnt_w = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] c_max_val = pow10(NDISP) - 64'd1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CONVERT  = 3'd1;
  localparam logic [2:0] S_WR_SEG   = 3'd2;
  localparam logic [2:0] S_RESP_SEG = 3'd3;
  localparam logic [2:0] S_WR_DP    = 3'd4;
  localparam logic [2:0] S_RESP_DP  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [c_bcd_w-1:0]    bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0]  shreg_q, shreg_d;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [NDISP-1:0]      dp_q, dp_d;
  logic [NDISP-1:0]      cache_q, cache_d;
  logic                  cache_vld_q, cache_vld_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;

  logic [c_bcd_w-1:0]    w_bcd_adj;
  logic [c_bcd_w-1:0]    w_bcd_shift;
  logic                  w_accept;
  logic                  w_ovf;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_fin;
  logic                  w_w_fin;
  logic                  w_dp_needed;

  // Double-dabble correction: each digit >= 5 gets +3 before the shift.
  for (genvar gi = 0; gi < NDISP; gi++) begin : g_digit
    assign w_bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
  end

  assign w_bcd_shift = {w_bcd_adj[c_bcd_w-2:0], shreg_q[BIN_WIDTH-1]};
  assign w_accept    = in_valid && in_ready_q;
  assign w_ovf       = 64'(in_value) > c_max_val;
  assign w_aw_hs     = awvalid_q && awready;
  assign w_w_hs      = wvalid_q && wready;
  assign w_aw_fin    = aw_done_q || w_aw_hs;
  assign w_w_fin     = w_done_q || w_w_hs;
  assign w_dp_needed = !cache_vld_q || (dp_q != cache_q);

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dp_d        = dp_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    ovf_d       = 1'b0;
    err_d       = err_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (w_accept) begin
          in_ready_d = 1'b0;
          dp_d       = in_dp;
          if (w_ovf) begin
            bcd_d     = '1;
            ovf_d     = 1'b1;
            state_d   = S_WR_SEG;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = ADDR_WIDTH'(ADDR_SEG);
            wdata_d   = DATA_WIDTH'({c_bcd_w{1'b1}});
          end else begin
            bcd_d   = '0;
            shreg_d = in_value;
            cnt_d   = c_cnt_w'(BIN_WIDTH - 1);
            state_d = S_CONVERT;
          end
        end
      end

      S_CONVERT: begin
        bcd_d   = w_bcd_shift;
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          state_d   = S_WR_SEG;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_WIDTH'(ADDR_SEG);
          wdata_d   = DATA_WIDTH'(w_bcd_shift);
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end

      S_WR_SEG, S_WR_DP: begin
        if (w_aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (w_aw_fin && w_w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (state_q == S_WR_SEG) ? S_RESP_SEG : S_RESP_DP;
        end
      end

      S_RESP_SEG: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          if (w_dp_needed) begin
            state_d   = S_WR_DP;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = ADDR_WIDTH'(ADDR_DP);
            wdata_d   = DATA_WIDTH'(dp_q);
          end else begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
          end
        end
      end

      S_RESP_DP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          // The cache tracks what the controller holds, error or not.
          cache_d     = dp_q;
          cache_vld_d = 1'b1;
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dp_q        <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dp_q        <= dp_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = (state_q != S_IDLE);
  assign overflow = ovf_q;
  assign err      = err_q;
  assign awaddr   = awaddr_q;
  assign awprot   = 3'b000;
  assign awvalid  = awvalid_q;
  assign wdata    = wdata_q;
  assign wstrb    = '1;
  assign wvalid   = wvalid_q;
  assign bready   = (state_q == S_RESP_SEG) || (state_q == S_RESP_DP);

endmodule

`default_nettype wire

// File: tb/tb_axi_7seg_bcd_writer.sv
// ============================================================================
// Module      : tb_axi_7seg_bcd_writer
// Description : Directed self-checking bench with a small AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_7seg_bcd_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [26:0] in_value = '0;
  logic [7:0]  in_dp = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, busy, overflow, err;
  logic [2:0]  awaddr, awprot;
  logic        awvalid, wvalid, bready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready = 1'b1;
  logic        wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  int          aw_hold = 0;
  bit          err_next = 1'b0;
  bit          aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  logic [2:0]  cur_addr;
  logic [31:0] cur_data;
  logic [2:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          n_ovf = 0;
  int          n_ovl = 0;

  axi_7seg_bcd_writer dut (
    .clk(clk), .rst(rst),
    .in_value(in_value), .in_dp(in_dp), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .overflow(overflow), .err(err),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Slave bookkeeping sampled on the active edge (pre-update values).
  always @(posedge clk) begin
    if (rst) begin
      aw_got = 1'b0;
      w_got  = 1'b0;
      b_pend = 1'b0;
    end else begin
      if (awvalid && b_pend) n_ovl++;
      if (overflow) n_ovf++;
      if (bvalid && bready) begin
        b_pend   = 1'b0;
        err_next = 1'b0;
      end
      if (awvalid && awready) begin
        aw_got   = 1'b1;
        cur_addr = awaddr;
      end
      if (wvalid && wready) begin
        w_got    = 1'b1;
        cur_data = wdata;
      end
      if (aw_got && w_got) begin
        log_addr.push_back(cur_addr);
        log_data.push_back(cur_data);
        aw_got = 1'b0;
        w_got  = 1'b0;
        b_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bvalid = b_pend;
    bresp  = (b_pend && err_next) ? 2'b10 : 2'b00;
    if (awvalid && aw_hold > 0) begin
      awready = 1'b0;
      aw_hold--;
    end else begin
      awready = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [26:0] v, input logic [7:0] d);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_send", in_ready, 1);
    in_value = v;
    in_dp    = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic meas_lat(output int k);
    k = 1;
    while (!awvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (!(in_ready && !busy && !b_pend) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, in_ready, 1);
  endtask

  initial begin
    int lat;
    int base;
    int ovf0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err", err, 0);
    check("awprot", awprot, 0);
    check("wstrb", wstrb, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // First request: segment write then DP write (cache invalid)
    base = log_addr.size();
    send(27'd12345678, 8'h04);
    meas_lat(lat);
    check("lat_convert_1", lat, 28);
    wait_idle("idle_1");
    check("nwr_1", log_addr.size() - base, 2);
    check("addr_1a", log_addr[base], 0);
    check("data_1a", log_data[base], 32'h12345678);
    check("addr_1b", log_addr[base+1], 4);
    check("data_1b", log_data[base+1], 32'h00000004);
    check("err_1", err, 0);

    // Same dp mask: segment write only
    base = log_addr.size();
    send(27'd42, 8'h04);
    meas_lat(lat);
    check("lat_convert_2", lat, 28);
    wait_idle("idle_2");
    check("nwr_2", log_addr.size() - base, 1);
    check("addr_2", log_addr[base], 0);
    check("data_2", log_data[base], 32'h00000042);

    // Overflow: all-F digits, no conversion cycles
    base = log_addr.size();
    ovf0 = n_ovf;
    send(27'd100000000, 8'h04);
    check("ovf_hi", overflow, 1);
    meas_lat(lat);
    check("lat_ovf", lat, 1);
    @(negedge clk);
    check("ovf_lo", overflow, 0);
    wait_idle("idle_3");
    check("ovf_pulses", n_ovf - ovf0, 1);
    check("nwr_3", log_addr.size() - base, 1);
    check("data_3", log_data[base], 32'hFFFFFFFF);

    // Largest in-range value
    base = log_addr.size();
    ovf0 = n_ovf;
    send(27'd99999999, 8'h04);
    meas_lat(lat);
    check("lat_max", lat, 28);
    wait_idle("idle_4");
    check("ovf_none_max", n_ovf - ovf0, 0);
    check("nwr_4", log_addr.size() - base, 1);
    check("data_4", log_data[base], 32'h99999999);

    // AW stalled for 5 cycles, W accepted immediately
    base = log_addr.size();
    aw_hold = 5;
    send(27'd7, 8'h04);
    meas_lat(lat);
    @(negedge clk);
    check("stall_wvalid_drop", wvalid, 0);
    check("stall_awvalid_hold", awvalid, 1);
    check("stall_awaddr", awaddr, 0);
    check("stall_wdata", wdata, 32'h00000007);
    repeat (2) @(negedge clk);
    check("stall_awvalid_hold2", awvalid, 1);
    check("stall_wdata2", wdata, 32'h00000007);
    wait_idle("idle_5");
    check("nwr_5", log_addr.size() - base, 1);
    check("data_5", log_data[base], 32'h00000007);

    // SLVERR on segment write; DP write still happens; err sticky
    base = log_addr.size();
    err_next = 1'b1;
    send(27'd55, 8'h81);
    wait_idle("idle_6");
    check("err_set", err, 1);
    check("nwr_6", log_addr.size() - base, 2);
    check("data_6a", log_data[base], 32'h00000055);
    check("addr_6b", log_addr[base+1], 4);
    check("data_6b", log_data[base+1], 32'h00000081);
    base = log_addr.size();
    send(27'd56, 8'h81);
    wait_idle("idle_7");
    check("err_sticky", err, 1);
    check("nwr_7", log_addr.size() - base, 1);
    check("data_7", log_data[base], 32'h00000056);

    // Reset mid-CONVERT
    send(27'd1234, 8'h81);
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_awvalid", awvalid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_awvalid", awvalid, 0);
    check("mrst_wvalid", wvalid, 0);
    check("mrst_bready", bready, 0);
    check("mrst_awaddr", awaddr, 0);
    check("mrst_wdata", wdata, 0);
    check("mrst_err", err, 0);
    check("mrst_overflow", overflow, 0);
    @(negedge clk);
    check("mrst_ready_back", in_ready, 1);
    base = log_addr.size();
    send(27'd1234, 8'h81);
    wait_idle("idle_8");
    check("nwr_8", log_addr.size() - base, 2);
    check("data_8a", log_data[base], 32'h00001234);
    check("addr_8b", log_addr[base+1], 4);
    check("data_8b", log_data[base+1], 32'h00000081);
    check("err_8", err, 0);

    check("one_outstanding", n_ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
